// File: rtl/pmem_line_responder_if.sv
// Cache <-> physical-memory line link: 32-bit line address, 256-bit data, read/write request and resp pulse.
// The cache drives the master side and the memory responder sits on the slave side.
interface pmem_line_responder_if;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport master (
    output pmem_address,
    output pmem_read,
    output pmem_write,
    output pmem_wdata,
    input  pmem_rdata,
    input  pmem_resp
  );

  modport slave (
    input  pmem_address,
    input  pmem_read,
    input  pmem_write,
    input  pmem_wdata,
    output pmem_rdata,
    output pmem_resp
  );
endinterface

// File: rtl/pmem_line_responder.sv
// Fixed-latency physical-memory responder for 256-bit cache lines, backed by an internal line array.
// Transactions are serialized; protocol violations set a sticky error flag.
module pmem_line_responder #(
  parameter int s_offset = 5,
  parameter int s_depth  = 8,
  parameter int LATENCY  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pmem_line_responder_if.slave  pmem,
  output logic                  pmem_error,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam int          LINES  = 2 ** s_depth;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [3:0]           cnt;
  logic [3:0]           cnt_next;

  logic [s_depth-1:0]   idx_q;
  logic                 write_q;
  logic [255:0]         wdata_q;
  logic [255:0]         rdata_q;

  logic [255:0]         mem [LINES];

  logic [s_depth-1:0]   req_idx;
  logic                 req_one;
  logic                 req_both;
  logic                 req_held;

  logic                 accept;
  logic                 commit;
  logic                 set_error;
  logic [s_depth-1:0]   commit_idx;
  logic                 commit_write;
  logic [255:0]         commit_wdata;

  logic                 unused_addr_bits;

  assign req_idx  = pmem.pmem_address[s_offset +: s_depth];
  assign req_one  = pmem.pmem_read ^ pmem.pmem_write;
  assign req_both = pmem.pmem_read & pmem.pmem_write;
  assign req_held = write_q ? pmem.pmem_write : pmem.pmem_read;

  assign unused_addr_bits = ^{pmem.pmem_address[s_offset-1:0],
                              pmem.pmem_address[31:s_offset+s_depth]};

  // With LATENCY==1 the commit happens on the accepting edge, so the live request is used directly.
  assign commit_idx   = (state == IDLE) ? req_idx          : idx_q;
  assign commit_write = (state == IDLE) ? pmem.pmem_write  : write_q;
  assign commit_wdata = (state == IDLE) ? pmem.pmem_wdata  : wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    set_error  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_both) begin
          set_error = 1'b1;
        end else if (req_one) begin
          accept   = 1'b1;
          cnt_next = LAT_M1;
          if (LAT_M1 == 4'd0) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        // A dropped request aborts even on the final countdown cycle.
        if (!req_held) begin
          set_error  = 1'b1;
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt == 4'd1) begin
          state_next = RESP;
          commit     = 1'b1;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q      <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      pmem_error <= 1'b0;
      rd_count   <= 16'd0;
      wr_count   <= 16'd0;
    end else begin
      if (accept) begin
        idx_q   <= req_idx;
        write_q <= pmem.pmem_write;
        wdata_q <= pmem.pmem_wdata;
      end
      if (set_error) begin
        pmem_error <= 1'b1;
      end
      if (commit) begin
        if (commit_write) begin
          if (wr_count != 16'hFFFF) begin
            wr_count <= wr_count + 16'd1;
          end
        end else begin
          rdata_q <= mem[commit_idx];
          if (rd_count != 16'hFFFF) begin
            rd_count <= rd_count + 16'd1;
          end
        end
      end
    end
  end

  // The line array has no reset so its contents survive rst; a write is dropped while rst is asserted.
  always_ff @(posedge clk) begin
    if (rst && commit && commit_write) begin
      mem[commit_idx] <= commit_wdata;
    end
  end

  assign pmem.pmem_resp  = (state == RESP);
  assign pmem.pmem_rdata = rdata_q;

endmodule
